aes_out_serializer: RTL and testbench
=====================================

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 The block SHALL have no parameters; block size is fixed at 128 bits (16 bytes).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 load  input  1  one-cycle strobe; in0..in3 hold a completed ciphertext block.
REQ-005 in0, in1, in2, in3  input  32 each  ciphertext words; in0 is the most significant word.
REQ-006 byte_out  output  8  current byte presented downstream.
REQ-007 byte_valid  output  1  byte_out is valid.
REQ-008 byte_ready  input  1  downstream accepts byte_out when byte_valid and byte_ready are both high at a rising edge.
REQ-009 busy  output  1  high while a block is held and not fully transferred.
REQ-010 done  output  1  one-cycle pulse after the 16th byte is accepted.
REQ-011 overflow  output  1  one-cycle pulse when a load is dropped.

Function
REQ-012 The block SHALL implement two states: IDLE (no block held) and SEND (block held, bytes pending).
- Byte index: 4-bit counter, 0..15.
- Holding register: 128 bits.
REQ-013 In IDLE, load=1 SHALL:
- capture {in0,in1,in2,in3} into the holding register;
- clear the index to 0;
- enter SEND.
- byte_valid and busy SHALL be high from the next cycle, so latency is 1 cycle from load to byte 0.
REQ-014 In SEND, byte_valid SHALL be 1, busy SHALL be 1, and byte_out SHALL equal the indexed byte of the holding register.
REQ-015 byte_out and the index SHALL stay stable while byte_valid=1 and byte_ready=0; the stall length is unlimited.
REQ-016 On each accepted transfer with index<15, the index SHALL increment by 1.
REQ-017 On an accepted transfer with index=15:
- done SHALL pulse high in the next cycle;
- the block SHALL return to IDLE, with byte_valid=0 and busy=0, unless REQ-018 applies.
REQ-018 If load=1 in the same cycle as the accepted transfer of index 15:
- the new block SHALL be captured;
- the index SHALL reset to 0 and the block SHALL remain in SEND;
- done SHALL still pulse;
- byte_valid SHALL stay continuously high (back-to-back, no bubble).
REQ-019 load=1 in SEND at any other time SHALL be ignored: the holding register and index SHALL be unchanged, and overflow SHALL pulse high in the next cycle.
REQ-020 In IDLE, byte_out SHALL be 8'h00.
- byte_ready SHALL be ignored.
- done and overflow SHALL be 0 except for the pulses defined above.
REQ-021 Index wrap: the index SHALL never advance beyond 15, and no byte SHALL be repeated or skipped.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL enter IDLE with:
- index=0 and holding register=0;
- byte_out=8'h00, byte_valid=0, busy=0, done=0, overflow=0.
REQ-023 rst SHALL take priority over load and byte_ready. Asserting rst mid-transfer SHALL abandon the block, and done SHALL NOT pulse for it.
REQ-024 The first load SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-025 Macro AES_SER_LSB_FIRST_EN SHALL select the byte order.
- Undefined (default): byte index k SHALL be bits [127-8k : 120-8k] of the holding register, so in0[31:24] is sent first and in3[7:0] last.
- Defined: byte index k SHALL be bits [8k+7 : 8k], so in3[7:0] is sent first and in0[31:24] last.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-026 Basic transfer, byte_ready tied 1:
- Stimulus: load with in0..in3 = 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF.
- Response: bytes 00,11,22,...,FF on 16 consecutive cycles starting 1 cycle after load; done pulses once in the cycle after FF; busy then falls.
- With AES_SER_LSB_FIRST_EN defined: the order is FF,EE,...,00.
REQ-027 Backpressure:
- Stimulus: same block; byte_ready=0 for 5 cycles while byte 3 (8'h33) is presented.
- Response: byte_out stays 8'h33 with byte_valid=1 for the whole stall, and transfer then resumes at 8'h44.
REQ-028 Dropped load:
- Stimulus: load a second block at index 7.
- Response: overflow pulses once, and the first block completes unchanged.
REQ-029 Back-to-back:
- Stimulus: load a second block (in0=32'hDEADBEEF) in the same cycle that byte 15 is accepted.
- Response: done pulses; byte_valid never drops; the next byte is 8'hDE.
REQ-030 Reset mid-operation:
- Stimulus: rst=1 at index 9.
- Response: all outputs zero next cycle; no done pulse; a fresh load then restarts from byte 0.

Source files
------------

// File: rtl/aes_out_serializer_if.sv
// Handshake bundle between a ciphertext producer, the byte serializer and the downstream byte sink.
// The master modport is the producer/sink side; the slave modport is the serializer.
interface aes_out_serializer_if;
  logic        load;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] in3;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output load, in0, in1, in2, in3, byte_ready,
    input  byte_out, byte_valid, busy, done, overflow
  );

  modport slave (
    input  load, in0, in1, in2, in3, byte_ready,
    output byte_out, byte_valid, busy, done, overflow
  );
endinterface

// File: rtl/aes_out_serializer.sv
// Serializes a 128-bit ciphertext block into 16 bytes over a valid/ready handshake.
// Define AES_SER_LSB_FIRST_EN to send in3[7:0] first instead of in0[31:24].
module aes_out_serializer (
  input  logic                 clk,
  input  logic                 rst,
  aes_out_serializer_if.slave  io_bus
);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t       r_state;
  state_t       w_stateNext;
  logic [3:0]   r_index;
  logic [3:0]   w_indexNext;
  logic [127:0] r_hold;
  logic [127:0] w_holdNext;
  logic         r_done;
  logic         w_doneNext;
  logic         r_overflow;
  logic         w_overflowNext;

  logic [127:0] w_block;
  logic         w_accept;
  logic         w_last;
  logic [7:0]   w_byteSel;

  assign w_block  = {io_bus.in0, io_bus.in1, io_bus.in2, io_bus.in3};
  assign w_accept = (r_state == ST_SEND) && io_bus.byte_ready;
  assign w_last   = w_accept && (r_index == 4'd15);

`ifdef AES_SER_LSB_FIRST_EN
  assign w_byteSel = r_hold[{r_index, 3'b000} +: 8];
`else
  assign w_byteSel = r_hold[{4'd15 - r_index, 3'b000} +: 8];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_index    <= 4'd0;
      r_hold     <= 128'd0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_index    <= w_indexNext;
      r_hold     <= w_holdNext;
      r_done     <= w_doneNext;
      r_overflow <= w_overflowNext;
    end
  end

  // A load coinciding with the final accepted byte refills the block without a bubble.
  always_comb begin
    w_stateNext    = r_state;
    w_indexNext    = r_index;
    w_holdNext     = r_hold;
    w_doneNext     = w_last;
    w_overflowNext = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.load) begin
          w_holdNext  = w_block;
          w_indexNext = 4'd0;
          w_stateNext = ST_SEND;
        end
      end
      ST_SEND: begin
        if (io_bus.load && !w_last) begin
          w_overflowNext = 1'b1;
        end
        if (w_last) begin
          w_indexNext = 4'd0;
          if (io_bus.load) begin
            w_holdNext = w_block;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end else if (w_accept) begin
          w_indexNext = r_index + 4'd1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign io_bus.byte_valid = (r_state == ST_SEND);
  assign io_bus.busy       = (r_state == ST_SEND);
  assign io_bus.byte_out   = (r_state == ST_SEND) ? w_byteSel : 8'h00;
  assign io_bus.done       = r_done;
  assign io_bus.overflow   = r_overflow;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed scenarios plus random traffic
// against a queue-based model of the byte stream.
module tb_aes_out_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_out_serializer_if bus ();

  aes_out_serializer dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [7:0]  mQ[$];
  bit          mDone;
  bit          mOvf;
  logic [31:0] curW[4];

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Byte k of a block in transmission order, derived from word/byte position.
  function automatic logic [7:0] blockByte(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3,
                                           input int k);
    logic [31:0] words[4];
    logic [31:0] sel;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
`ifdef AES_SER_LSB_FIRST_EN
    sel = words[3 - k / 4] >> (8 * (k % 4));
`else
    sel = words[k / 4] >> (8 * (3 - k % 4));
`endif
    return sel[7:0];
  endfunction

  function automatic logic [7:0] expA(input int k);
`ifdef AES_SER_LSB_FIRST_EN
    return 8'(8'h11 * (15 - k));
`else
    return 8'(8'h11 * k);
`endif
  endfunction

  task automatic checkOutput();
    logic [7:0] expByte;
    expByte = (mQ.size() > 0) ? mQ[0] : 8'h00;
    checkEq("byte_out",   bus.byte_out,          expByte);
    checkEq("byte_valid", {7'd0, bus.byte_valid}, {7'd0, mQ.size() > 0});
    checkEq("busy",       {7'd0, bus.busy},       {7'd0, mQ.size() > 0});
    checkEq("done",       {7'd0, bus.done},       {7'd0, mDone});
    checkEq("overflow",   {7'd0, bus.overflow},   {7'd0, mOvf});
  endtask

  task automatic applyStimulus(input bit iRst, input bit iLoad,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input bit iReady);
    bit held;
    bit last;
    rst            = iRst;
    bus.load       = iLoad;
    bus.in0        = w0;
    bus.in1        = w1;
    bus.in2        = w2;
    bus.in3        = w3;
    bus.byte_ready = iReady;
    @(posedge clk);
    if (iRst) begin
      mQ.delete();
      mDone = 1'b0;
      mOvf  = 1'b0;
    end else begin
      held  = (mQ.size() > 0);
      last  = held && iReady && (mQ.size() == 1);
      mDone = last;
      mOvf  = iLoad && held && !last;
      if (held && iReady) void'(mQ.pop_front());
      if (iLoad && (!held || last)) begin
        for (int k = 0; k < 16; k++) mQ.push_back(blockByte(w0, w1, w2, w3, k));
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic tick(input bit iLoad, input bit iReady);
    applyStimulus(1'b0, iLoad, curW[0], curW[1], curW[2], curW[3], iReady);
  endtask

  initial begin
    curW[0] = 32'h00112233;
    curW[1] = 32'h44556677;
    curW[2] = 32'h8899AABB;
    curW[3] = 32'hCCDDEEFF;
    bus.load = 1'b0;
    bus.byte_ready = 1'b1;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    mDone = 1'b0;
    mOvf  = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, curW[0], curW[1], curW[2], curW[3], 1'b1);
    applyStimulus(1'b1, 1'b0, curW[0], curW[1], curW[2], curW[3], 1'b1);
    checkEq("reset_byte_out", bus.byte_out, 8'h00);

    $display("[TB] basic transfer, load right after reset");
    tick(1'b1, 1'b1);
    checkEq("basic_byte0", bus.byte_out, expA(0));
    for (int j = 1; j < 16; j++) begin
      tick(1'b0, 1'b1);
      checkEq("basic_byte", bus.byte_out, expA(j));
    end
    tick(1'b0, 1'b1);
    checkEq("basic_done", {7'd0, bus.done}, 8'd1);
    checkEq("basic_busy_low", {7'd0, bus.busy}, 8'd0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);

    $display("[TB] backpressure at byte 3");
    tick(1'b1, 1'b1);
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 1'b0);
      checkEq("stall_byte", bus.byte_out, expA(3));
    end
    tick(1'b0, 1'b1);
    checkEq("resume_byte", bus.byte_out, expA(4));
    for (int j = 0; j < 14; j++) tick(1'b0, 1'b1);

    $display("[TB] dropped load at index 7");
    tick(1'b1, 1'b1);
    for (int j = 0; j < 7; j++) tick(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1);
    checkEq("drop_overflow", {7'd0, bus.overflow}, 8'd1);
    checkEq("drop_byte8", bus.byte_out, expA(8));
    for (int j = 0; j < 10; j++) tick(1'b0, 1'b1);

    $display("[TB] back-to-back load on byte 15");
    tick(1'b1, 1'b1);
    for (int j = 0; j < 15; j++) tick(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h01234567, 1'b1);
    checkEq("b2b_done", {7'd0, bus.done}, 8'd1);
    checkEq("b2b_valid", {7'd0, bus.byte_valid}, 8'd1);
`ifdef AES_SER_LSB_FIRST_EN
    checkEq("b2b_first", bus.byte_out, 8'h67);
`else
    checkEq("b2b_first", bus.byte_out, 8'hDE);
`endif
    for (int j = 0; j < 17; j++) tick(1'b0, 1'b1);

    $display("[TB] reset mid-transfer at index 9");
    tick(1'b1, 1'b1);
    for (int j = 0; j < 9; j++) tick(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, curW[0], curW[1], curW[2], curW[3], 1'b1);
    checkEq("rst_mid_valid", {7'd0, bus.byte_valid}, 8'd0);
    tick(1'b0, 1'b1);
    checkEq("rst_mid_no_done", {7'd0, bus.done}, 8'd0);
    tick(1'b1, 1'b1);
    checkEq("rst_restart_byte0", bus.byte_out, expA(0));
    for (int j = 0; j < 17; j++) tick(1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                    $urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
